// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit/request-to-send, shifts data, odd
// parity and stop on device clocks, checks the device acknowledge.
module ps2_host_tx #(
   parameter int unsigned FREQ_HZ    = 25_000_000,
   parameter int unsigned INHIBIT_US = 100,
   parameter int unsigned TIMEOUT_US = 20000
) (
   input  logic       clk,
   input  logic       reset_i,
   input  logic [7:0] data_i,
   input  logic       valid_i,
   output logic       ready_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       err_o,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe_o,
   output logic       ps2_data_oe_o
);

   localparam int unsigned INH   = FREQ_HZ / 1_000_000 * INHIBIT_US;
   localparam int unsigned TMO   = FREQ_HZ / 1_000_000 * TIMEOUT_US;
   localparam int unsigned CW    = $clog2(TMO + 1);
   localparam int unsigned SW    = 10;
   localparam int unsigned BW    = 4;
   localparam int unsigned NFALL = 10;

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_START, S_BITS, S_ACK, S_WAIT_IDLE
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      clk_sync, data_sync;
   logic            clk_prev;
   logic            clk_s, data_s, fall;
   logic [CW-1:0]   wd_q;
   logic [BW-1:0]   bit_q;
   logic [SW-1:0]   sh_q;
   logic            accept, tmo;
   logic            clk_oe_d, data_oe_d, busy_d, done_d, err_d;

   // Pin synchronizers and falling-edge detect on the device clock
   always_ff @(posedge clk) begin
      if (reset_i) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk_i};
         data_sync <= {data_sync[0], ps2_data_i};
         clk_prev  <= clk_sync[1];
      end
   end

   assign clk_s  = clk_sync[1];
   assign data_s = data_sync[1];
   assign fall   = clk_prev & ~clk_s;

   assign ready_o = (state_q == S_IDLE) && !reset_i;
   assign accept  = valid_i && ready_o;
   assign tmo     = (state_q != S_IDLE) && (wd_q == CW'(TMO - 1));

   // Watchdog/inhibit counter, bit counter and shift word
   always_ff @(posedge clk) begin
      if (reset_i) begin
         wd_q  <= '0;
         bit_q <= '0;
         sh_q  <= '1;
      end else if (state_q == S_IDLE) begin
         wd_q  <= '0;
         bit_q <= '0;
         if (accept) sh_q <= {1'b1, ~^data_i, data_i};
      end else begin
         wd_q <= wd_q + CW'(1);
         if (state_q == S_BITS && fall) begin
            bit_q <= bit_q + BW'(1);
            sh_q  <= {1'b1, sh_q[SW-1:1]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Next state; the watchdog overrides everything outside IDLE
   always_comb begin
      state_d = state_q;
      if (tmo) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE:      if (accept) state_d = S_INHIBIT;
            S_INHIBIT:   if (wd_q == CW'(INH - 1)) state_d = S_START;
            S_START:     state_d = S_BITS;
            S_BITS:      if (fall && bit_q == BW'(NFALL)) state_d = S_ACK;
            S_ACK:       state_d = data_s ? S_IDLE : S_WAIT_IDLE;
            S_WAIT_IDLE: if (clk_s && data_s) state_d = S_IDLE;
            default:     state_d = S_IDLE;
         endcase
      end
   end

   // Next values of the registered outputs
   always_comb begin
      clk_oe_d  = (state_d == S_INHIBIT);
      busy_d    = (state_d != S_IDLE);
      data_oe_d = ps2_data_oe_o;
      done_d    = !tmo && (state_q == S_WAIT_IDLE) && clk_s && data_s;
      err_d     = tmo || ((state_q == S_ACK) && data_s);
      unique case (state_d)
         S_START: data_oe_d = 1'b1;
         S_BITS:  if (state_q == S_BITS && fall) data_oe_d = ~sh_q[0];
         default: data_oe_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         ps2_clk_oe_o  <= 1'b0;
         ps2_data_oe_o <= 1'b0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         err_o         <= 1'b0;
      end else begin
         ps2_clk_oe_o  <= clk_oe_d;
         ps2_data_oe_o <= data_oe_d;
         busy_o        <= busy_d;
         done_o        <= done_d;
         err_o         <= err_d;
      end
   end

endmodule
